// File: rtl/video_crypto_pkg.sv
// Shared definitions for the video scrambling path.
//  - LFSR width and Galois feedback mask (x^32 + x^22 + x^2 + x + 1)
//  - State encoding of the cut position generator
//  - Active line size shared with line_rotator
//  - Single-step Galois LFSR helper
package video_crypto_pkg;

  localparam int          LFSR_WIDTH       = 32;
  localparam logic [31:0] LFSR_POLY        = 32'h8020_0003;
  localparam int          ACTIVE_LINE_SIZE = 720;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_V = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_VBLANK = 2'd3
  } cpg_state_t;

  // One Galois shift to the right: the bit falling out of bit 0 folds the
  // polynomial mask back into the register.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    logic [LFSR_WIDTH-1:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ LFSR_POLY;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational K-fold Galois LFSR advance.
// Ports:
//   din   in  32  current LFSR state
//   dout  out 32  state after K single steps
module lfsr_step
  import video_crypto_pkg::*;
#(
  parameter int K = 8
) (
  input  logic [LFSR_WIDTH-1:0] din,
  output logic [LFSR_WIDTH-1:0] dout
);

  logic [LFSR_WIDTH-1:0] s;

  always_comb begin
    s = din;
    for (int i = 0; i < K; i++) begin
      s = lfsr_next(s);
    end
    dout = s;
  end

endmodule

// File: rtl/cut_position_generator.sv
// Keyed per-line pseudo-random source of the raw cut position for
// line_rotator. Reseeds at every field start from the key shadow and the
// field counter, so scrambler and descrambler with the same key agree and
// a late-joining descrambler locks on at the next field.
// Ports:
//   clk               in   1   pixel clock
//   reset_n           in   1   async active-low reset
//   enable            in   1   0: idle, outputs forced to 0
//   key               in   32  scrambling key
//   key_load          in   1   pulse: capture key into shadow (applied at next V fall)
//   V                 in   1   vertical blanking flag (1 = blanking)
//   H                 in   1   horizontal blanking flag (1 = blanking)
//   raw_cut_position  out  8   cut position for the next active line
//   cut_valid         out  1   a seeded sequence drives raw_cut_position
//   frame_count       out  16  fields since last key apply
//
// Handshake: there is no valid/ready pair here; raw_cut_position changes only
// on the clock edge that first samples H high inside a seeded field, so it is
// stable for the whole following H=0 interval. cut_valid qualifies it.
module cut_position_generator
  import video_crypto_pkg::*;
#(
  parameter int STEPS_PER_LINE = 8,
  parameter int FRAME_CNT_BITS = 16   // must be LFSR_WIDTH/2 for the seed mix
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [31:0]               key,
  input  logic                      key_load,
  input  logic                      V,
  input  logic                      H,
  output logic [7:0]                raw_cut_position,
  output logic                      cut_valid,
  output logic [FRAME_CNT_BITS-1:0] frame_count
);

  cpg_state_t state, state_n;

  logic                      prev_h, prev_v;
  logic                      h_rise, v_fall, v_rise;
  logic [LFSR_WIDTH-1:0]     lfsr, lfsr_n;
  logic [LFSR_WIDTH-1:0]     key_shadow, key_shadow_n;
  logic                      key_pending, key_pending_n;
  logic [LFSR_WIDTH-1:0]     eff_key, seed_raw, seed, base, stepped;
  logic [FRAME_CNT_BITS-1:0] seed_fc, frame_count_n;
  logic                      seeding, key_apply;
  logic [7:0]                raw_n;
  logic                      cut_valid_n;

  assign h_rise = !prev_h && H;
  assign v_fall = prev_v && !V;
  assign v_rise = !prev_v && V;

  // A field is (re)seeded on V fall from WAIT_V or VBLANK while enabled.
  assign seeding   = enable && v_fall && (state == ST_WAIT_V || state == ST_VBLANK);
  assign key_apply = seeding && (key_pending || key_load);

  // A key loaded in the seeding cycle itself is used straight from the port.
  assign eff_key  = key_load ? key : key_shadow;
  assign seed_fc  = key_apply ? '0 : frame_count;
  assign seed_raw = eff_key ^ {seed_fc, ~seed_fc};
  assign seed     = (seed_raw == '0) ? {{(LFSR_WIDTH-1){1'b0}}, 1'b1} : seed_raw;

  // Coincident V fall and H rise advance directly from the new seed.
  assign base = v_fall ? seed : lfsr;

  lfsr_step #(.K(STEPS_PER_LINE)) u_step (
    .din  (base),
    .dout (stepped)
  );

  always_comb begin
    state_n       = state;
    lfsr_n        = lfsr;
    raw_n         = raw_cut_position;
    cut_valid_n   = cut_valid;
    frame_count_n = frame_count;
    key_shadow_n  = key_load ? key : key_shadow;
    key_pending_n = key_load ? 1'b1 : key_pending;

    if (key_apply) begin
      frame_count_n = '0;
      key_pending_n = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        raw_n       = '0;
        cut_valid_n = 1'b0;
        if (enable) state_n = ST_WAIT_V;
      end
      ST_WAIT_V, ST_VBLANK: begin
        if (v_fall) begin
          lfsr_n      = seed;
          cut_valid_n = 1'b1;
          state_n     = ST_ACTIVE;
          if (h_rise) begin
            lfsr_n = stepped;
            raw_n  = stepped[7:0];
          end
        end
      end
      ST_ACTIVE: begin
        if (h_rise && !V) begin
          lfsr_n = stepped;
          raw_n  = stepped[7:0];
        end
        if (v_rise) begin
          state_n       = ST_VBLANK;
          frame_count_n = frame_count + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Disable overrides everything except the key shadow; lfsr and the
    // field counter hold so nothing is lost beyond the current field.
    if (!enable) begin
      state_n       = ST_IDLE;
      raw_n         = '0;
      cut_valid_n   = 1'b0;
      lfsr_n        = lfsr;
      frame_count_n = frame_count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      prev_h           <= H;   // track inputs so release creates no false edge
      prev_v           <= V;
      lfsr             <= {{(LFSR_WIDTH-1){1'b0}}, 1'b1};
      key_shadow       <= '0;
      key_pending      <= 1'b0;
      raw_cut_position <= '0;
      cut_valid        <= 1'b0;
      frame_count      <= '0;
    end else begin
      state            <= state_n;
      prev_h           <= H;
      prev_v           <= V;
      lfsr             <= lfsr_n;
      key_shadow       <= key_shadow_n;
      key_pending      <= key_pending_n;
      raw_cut_position <= raw_n;
      cut_valid        <= cut_valid_n;
      frame_count      <= frame_count_n;
    end
  end

endmodule

// File: tb/tb_cut_position_generator.sv
module tb_cut_position_generator;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] key;
  logic        key_load;
  logic        V;
  logic        H;
  logic [7:0]  raw_cut_position;
  logic        cut_valid;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  cut_position_generator dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .key              (key),
    .key_load         (key_load),
    .V                (V),
    .H                (H),
    .raw_cut_position (raw_cut_position),
    .cut_valid        (cut_valid),
    .frame_count      (frame_count)
  );

  // ---------------- scoreboard / reference ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  logic [31:0] m_lfsr;
  logic [31:0] m_shadow;
  logic        m_pending;
  logic [15:0] m_fc;
  logic [7:0]  m_raw;
  logic        m_valid;
  logic        m_in_field;

  typedef struct {
    logic [31:0] key;
    int          load_mode;  // 0 none, 1 in vblank, 2 mid field, 3 at V fall
    int          vbl_lines;
    int          act_lines;
    bit          coinc;      // V fall coincides with H rise
    logic [15:0] exp_fc;
  } field_vec_t;

  function automatic logic [31:0] ref_step8(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_seed(input logic [31:0] k, input logic [15:0] fc);
    logic [31:0] s;
    s = k ^ {fc, ~fc};
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pop();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("raw_line", {24'h0, raw_cut_position}, {24'h0, e});
    end
  endtask

  // Reference bookkeeping at a field start (V fall).
  task automatic model_seed();
    if (m_pending) begin
      m_fc      = 16'h0;
      m_pending = 1'b0;
    end
    m_lfsr     = ref_seed(m_shadow, m_fc);
    m_valid    = 1'b1;
    m_in_field = 1'b1;
  endtask

  task automatic model_advance();
    m_lfsr = ref_step8(m_lfsr);
    m_raw  = m_lfsr[7:0];
    exp_q.push_back(m_raw);
  endtask

  // ---------------- driver tasks ----------------
  // One line: act_cycles of H=0, then 4 cycles of H=1. Inputs change at negedge.
  task automatic do_line(input bit adv, input bit kl, input int act_cycles);
    H = 1'b0;
    if (kl) begin
      key_load  = 1'b1;
      m_shadow  = key;
      m_pending = 1'b1;
    end
    for (int c = 0; c < act_cycles; c++) begin
      @(negedge clk);
      key_load = 1'b0;
    end
    chk("raw_hold", {24'h0, raw_cut_position}, {24'h0, m_raw});
    H = 1'b1;
    if (adv) model_advance();
    @(negedge clk);
    if (adv) check_pop();
    repeat (3) @(negedge clk);
  endtask

  task automatic run_field(input field_vec_t v);
    key = v.key;
    V   = 1'b1;
    if (m_in_field) m_fc++;
    m_in_field = 1'b0;
    for (int i = 0; i < v.vbl_lines; i++) begin
      do_line(1'b0, (v.load_mode == 1 && i == 0), 4);
    end
    chk("valid_pre", {31'h0, cut_valid}, {31'h0, m_valid});
    if (v.coinc) begin
      H = 1'b0;
      repeat (4) @(negedge clk);
      chk("raw_hold", {24'h0, raw_cut_position}, {24'h0, m_raw});
      H = 1'b1;
      V = 1'b0;
      model_seed();
      model_advance();
      @(negedge clk);
      check_pop();
      chk("valid_seed", {31'h0, cut_valid}, 32'd1);
      chk("fc_seed", {16'h0, frame_count}, {16'h0, v.exp_fc});
      repeat (3) @(negedge clk);
      for (int i = 0; i < v.act_lines; i++) begin
        do_line(1'b1, (v.load_mode == 2 && i == 1), 4);
      end
    end else begin
      H = 1'b0;
      V = 1'b0;
      if (v.load_mode == 3) begin
        key_load  = 1'b1;
        m_shadow  = key;
        m_pending = 1'b1;
      end
      model_seed();
      @(negedge clk);
      key_load = 1'b0;
      chk("valid_seed", {31'h0, cut_valid}, 32'd1);
      chk("fc_seed", {16'h0, frame_count}, {16'h0, v.exp_fc});
      do_line(1'b1, 1'b0, 3);
      for (int i = 1; i < v.act_lines; i++) begin
        do_line(1'b1, (v.load_mode == 2 && i == 1), 4);
      end
    end
  endtask

  task automatic model_reset();
    m_lfsr     = 32'h1;
    m_shadow   = 32'h0;
    m_pending  = 1'b0;
    m_fc       = 16'h0;
    m_raw      = 8'h0;
    m_valid    = 1'b0;
    m_in_field = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  field_vec_t vecs[8];
  field_vec_t hv;

  initial begin
    vecs[0] = '{32'hDEAD_BEEF, 1, 2, 3,    1'b0, 16'd0};  // first keyed field
    vecs[1] = '{32'h0,         0, 2, 3,    1'b0, 16'd1};  // back-to-back field
    vecs[2] = '{32'h0,         0, 1, 2,    1'b1, 16'd2};  // V fall with H rise
    vecs[3] = '{32'h1234_5678, 2, 2, 3,    1'b0, 16'd3};  // key load mid field
    vecs[4] = '{32'h0,         0, 2, 3,    1'b0, 16'd0};  // new key applied
    vecs[5] = '{32'hCAFE_0001, 3, 1, 2,    1'b0, 16'd0};  // key load at V fall
    vecs[6] = '{32'h0000_FFFF, 1, 1, 1000, 1'b0, 16'd0};  // seed computes zero
    vecs[7] = '{32'h0,         0, 2, 2,    1'b1, 16'd1};

    reset_n  = 1'b0;
    enable   = 1'b0;
    key      = 32'h0;
    key_load = 1'b0;
    H        = 1'b1;
    V        = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_raw",   {24'h0, raw_cut_position}, 32'd0);
    chk("rst_valid", {31'h0, cut_valid}, 32'd0);
    chk("rst_fc",    {16'h0, frame_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // idle: lines pass but nothing is produced
    do_line(1'b0, 1'b0, 4);
    chk("idle_valid", {31'h0, cut_valid}, 32'd0);

    enable = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      run_field(vecs[t]);
    end

    // enable dropped mid-line
    H = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    m_raw = 8'h0; m_valid = 1'b0; m_in_field = 1'b0;
    chk("dis_raw",   {24'h0, raw_cut_position}, 32'd0);
    chk("dis_valid", {31'h0, cut_valid}, 32'd0);
    chk("dis_fc",    {16'h0, frame_count}, 32'd1);
    enable = 1'b1;
    do_line(1'b0, 1'b0, 1);
    do_line(1'b0, 1'b0, 4);   // WAIT_V: no advance yet
    hv = '{32'h0, 0, 1, 3, 1'b0, 16'd1};
    run_field(hv);

    // async reset mid-line
    H = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_raw",   {24'h0, raw_cut_position}, 32'd0);
    chk("arst_valid", {31'h0, cut_valid}, 32'd0);
    chk("arst_fc",    {16'h0, frame_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_line(1'b0, 1'b0, 2);
    hv = '{32'h0, 0, 1, 3, 1'b0, 16'd0};
    run_field(hv);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
